// File: rtl/csa_pkg.sv
// Constant helpers for sizing the pipelined carry-save reduction tree.
package csa_pkg;

    function automatic int unsigned csa_next(input int unsigned n);
        return (n > 2) ? (2 * (n / 3) + n % 3) : n;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned r;
        int unsigned lv;
        r  = n;
        lv = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (r > 2) begin
                r  = csa_next(r);
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
        int unsigned r;
        r = n;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < lvl) r = csa_next(r);
        end
        return r;
    endfunction

    // Total rows held by levels 0..lvl-1; used to place each level in one flat bus.
    function automatic int unsigned csa_row_off(input int unsigned n, input int unsigned lvl);
        int unsigned r;
        int unsigned off;
        r   = n;
        off = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < lvl) begin
                off = off + r;
                r   = csa_next(r);
            end
        end
        return off;
    endfunction

    function automatic int unsigned csa_out_w(input int unsigned width, input int unsigned n);
        return width + $clog2(n);
    endfunction

    function automatic int unsigned csa_num_rstages(input int unsigned n, input int unsigned lps);
        return (csa_levels(n) + lps - 1) / lps;
    endfunction

    // Level count reached at the output of reduction stage k (last stage may be short).
    function automatic int unsigned csa_stage_end(input int unsigned n, input int unsigned lps,
                                                  input int unsigned k);
        int unsigned e;
        e = (k + 1) * lps;
        return (e < csa_levels(n)) ? e : csa_levels(n);
    endfunction

    // Row offset of register bank k inside the flat bank bus.
    function automatic int unsigned csa_bank_off(input int unsigned n, input int unsigned lps,
                                                 input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < 64; j++) begin
            if (j < k) off = off + csa_rows(n, csa_stage_end(n, lps, j));
        end
        return off;
    endfunction

endpackage

// File: rtl/csa_3_2.sv
// Word-wide 3:2 compressor; carry row comes out already shifted to its weight.
module csa_3_2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    // Majority of the top bit would land above the result width and is dropped.
    assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) |
                      (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_stage.sv
// Combinational reduction of R rows through L levels of 3:2 compressors.
module csa_tree_stage
    import csa_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned R = 8,
    parameter int unsigned L = 1,
    localparam int unsigned RO = csa_rows(R, L)
) (
    input  logic [R*W-1:0]  rows_i,
    output logic [RO*W-1:0] rows_o
);

    localparam int unsigned TOT = csa_row_off(R, L + 1);

    // Every level's rows live back to back in one bus.
    logic [TOT*W-1:0] bus;

    assign bus[0 +: R*W] = rows_i;

    for (genvar lv = 0; lv < L; lv++) begin : g_lvl
        localparam int unsigned NI = csa_rows(R, lv);
        localparam int unsigned T  = NI / 3;
        localparam int unsigned LO = NI % 3;
        localparam int unsigned BI = csa_row_off(R, lv) * W;
        localparam int unsigned BO = csa_row_off(R, lv + 1) * W;

        for (genvar t = 0; t < T; t++) begin : g_csa
            csa_3_2 #(.W(W)) u_csa (
                .a_i    (bus[BI + (3*t)*W   +: W]),
                .b_i    (bus[BI + (3*t+1)*W +: W]),
                .c_i    (bus[BI + (3*t+2)*W +: W]),
                .sum_o  (bus[BO + (2*t)*W   +: W]),
                .carry_o(bus[BO + (2*t+1)*W +: W])
            );
        end

        if (LO > 0) begin : g_pass
            assign bus[BO + 2*T*W +: LO*W] = bus[BI + 3*T*W +: LO*W];
        end
    end

    assign rows_o = bus[csa_row_off(R, L)*W +: RO*W];

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand carry-save tree with valid/ready flow control,
// optional registered final adder and a pass-through user tag.
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned NUM_OPS          = 8,
    parameter int unsigned LEVELS_PER_STAGE = 1,
    parameter int unsigned FINAL_ADD        = 1,
    parameter int unsigned SIGNED           = 0,
    parameter int unsigned USER_W           = 1,
    localparam int unsigned OUT_W           = csa_out_w(WIDTH, NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic [USER_W-1:0]        in_user,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_sum,
    output logic [OUT_W-1:0]         out_carry,
    output logic [USER_W-1:0]        out_user,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned NSR       = csa_num_rstages(NUM_OPS, LEVELS_PER_STAGE);
    localparam int unsigned STAGES    = NSR + FINAL_ADD;
    localparam int unsigned BANK_ROWS = csa_bank_off(NUM_OPS, LEVELS_PER_STAGE, NSR);
    localparam int unsigned LAST_OFF  = csa_bank_off(NUM_OPS, LEVELS_PER_STAGE, NSR - 1);

    logic [NUM_OPS*OUT_W-1:0] ext_ops;
    logic [BANK_ROWS*OUT_W-1:0] bank_rows;
    logic [STAGES-1:0]          valid_q;
    logic [STAGES*USER_W-1:0]   user_q;
    logic [STAGES-1:0]          adv;
    logic [OUT_W-1:0]           row0;
    logic [OUT_W-1:0]           row1;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_ext
        assign ext_ops[i*OUT_W +: OUT_W] =
            {{(OUT_W-WIDTH){(SIGNED != 0) & in_ops[i*WIDTH + WIDTH - 1]}}, in_ops[i*WIDTH +: WIDTH]};
    end

    // Ready chain: a stage may load when it is empty or its successor is loading.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0] && !rst;

    for (genvar k = 0; k < NSR; k++) begin : g_stage
        localparam int unsigned LV_LO = k * LEVELS_PER_STAGE;
        localparam int unsigned LV_HI = csa_stage_end(NUM_OPS, LEVELS_PER_STAGE, k);
        localparam int unsigned RI    = csa_rows(NUM_OPS, LV_LO);
        localparam int unsigned RO    = csa_rows(NUM_OPS, LV_HI);
        localparam int unsigned OFF_O = csa_bank_off(NUM_OPS, LEVELS_PER_STAGE, k);

        logic [RI*OUT_W-1:0] rows_in;
        logic [RO*OUT_W-1:0] rows_d;
        logic [RO*OUT_W-1:0] rows_q;
        logic                load;

        if (k == 0) begin : g_in0
            assign rows_in = ext_ops;
            assign load    = in_valid && adv[0];
        end else begin : g_inn
            localparam int unsigned OFF_I = csa_bank_off(NUM_OPS, LEVELS_PER_STAGE, k - 1);
            assign rows_in = bank_rows[OFF_I*OUT_W +: RI*OUT_W];
            assign load    = adv[k] && valid_q[k-1];
        end

        csa_tree_stage #(.W(OUT_W), .R(RI), .L(LV_HI - LV_LO)) u_stage (
            .rows_i(rows_in),
            .rows_o(rows_d)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                rows_q <= '0;
            end else if (load) begin
                rows_q <= rows_d;
            end
        end

        assign bank_rows[OFF_O*OUT_W +: RO*OUT_W] = rows_q;
    end

    // Valid and tag shift alongside the data banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            user_q  <= '0;
        end else begin
            if (adv[0]) valid_q[0] <= in_valid;
            if (adv[0] && in_valid) user_q[0 +: USER_W] <= in_user;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) user_q[k*USER_W +: USER_W] <= user_q[(k-1)*USER_W +: USER_W];
                end
            end
        end
    end

    assign row0 = bank_rows[LAST_OFF*OUT_W +: OUT_W];
    assign row1 = bank_rows[(LAST_OFF+1)*OUT_W +: OUT_W];

    if (FINAL_ADD != 0) begin : g_fadd
        logic [OUT_W-1:0] fsum_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                fsum_q <= '0;
            end else if (adv[STAGES-1] && valid_q[STAGES-2]) begin
                fsum_q <= row0 + row1;
            end
        end

        assign out_sum   = fsum_q;
        assign out_carry = '0;
    end else begin : g_pair
        assign out_sum   = row0;
        assign out_carry = row1;
    end

    assign out_user  = user_q[(STAGES-1)*USER_W +: USER_W];
    assign out_valid = valid_q[STAGES-1];

endmodule
